// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (data + ctrl, ctrl masked on bubbles). 1-cycle latency, flush squashes all entries.
// Backpressure: out_ready stalls; SKID=1 absorbs one extra beat with registered in_ready, SKID=0 has in_ready = out_ready | !m_valid.
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush_i,
   output logic [1:0]        occ_o
);

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

   logic accept;
   logic m_free;

   generate
      if (SKID != 0) begin : g_skid
         // Registered ready: no combinational path from out_ready.
         assign in_ready = !s_valid_q;
      end else begin : g_noskid
         assign in_ready = out_ready | !m_valid_q;
      end
   endgenerate

   assign accept    = in_valid & in_ready;
   assign m_free    = !m_valid_q | out_ready;
   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
   assign occ_o     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;

      if (m_free) begin
         // The skid entry is always older than any new input beat.
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            s_valid_d = 1'b0;
         end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = in_ctrl;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept && (SKID != 0)) begin
         s_valid_d = 1'b1;
         s_data_d  = in_data;
         s_ctrl_d  = in_ctrl;
      end

      if (flush_i) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ctrl_q  <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_ctrl_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ctrl_q  <= m_ctrl_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_ctrl_q  <= s_ctrl_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance (a_*) and one SKID=0 instance (b_*).
module tb_pipe_stage_reg;

   logic        clk;
   logic        rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
   logic [63:0] a_in_data, a_out_data;
   logic [7:0]  a_in_ctrl, a_out_ctrl;
   logic [1:0]  a_occ;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
   logic [63:0] b_in_data, b_out_data;
   logic [7:0]  b_in_ctrl, b_out_ctrl;
   logic [1:0]  b_occ;

   int n_chk  = 0;
   int n_fail = 0;

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut1 (
      .clk_i(clk), .rst_i(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .flush_i(a_flush), .occ_o(a_occ)
   );

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
      .clk_i(clk), .rst_i(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .flush_i(b_flush), .occ_o(b_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      logic       or_tab   [5];
      logic [7:0] dat_tab  [5];
      logic [7:0] exp_out  [5];

      rst_n = 1'b0;
      a_in_valid = 0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 0; a_flush = 0;
      b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 0; b_flush = 0;
      #12;
      chk("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
      chk("rst_a_data",  a_out_data, 64'd0);
      chk("rst_a_ctrl",  {56'd0, a_out_ctrl}, 64'd0);
      chk("rst_a_occ",   {62'd0, a_occ}, 64'd0);
      chk("rst_a_ready", {63'd0, a_in_ready}, 64'd1);
      chk("rst_b_ready", {63'd0, b_in_ready}, 64'd1);
      chk("rst_b_occ",   {62'd0, b_occ}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Streaming: 8 back-to-back beats, each visible one edge after acceptance.
      a_out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         a_in_valid = 1; a_in_data = 64'(i); a_in_ctrl = 8'(i);
         #1;
         chk("stream_in_ready", {63'd0, a_in_ready}, 64'd1);
         tick();
         chk("stream_valid", {63'd0, a_out_valid}, 64'd1);
         chk("stream_data", a_out_data, 64'(i));
      end
      a_in_valid = 0;
      tick();
      chk("stream_end_valid", {63'd0, a_out_valid}, 64'd0);
      chk("stream_end_occ", {62'd0, a_occ}, 64'd0);

      // Stall: A held, B skidded, C refused until drain.
      a_in_valid = 1; a_in_data = 64'hA; a_in_ctrl = 8'h0A;
      tick();
      a_out_ready = 0; a_in_data = 64'hB; a_in_ctrl = 8'h0B;
      tick();
      chk("stall_data_A", a_out_data, 64'hA);
      chk("stall_occ2", {62'd0, a_occ}, 64'd2);
      chk("stall_in_ready0", {63'd0, a_in_ready}, 64'd0);
      a_in_data = 64'hC; a_in_ctrl = 8'h0C;
      tick();
      chk("stall_hold_A", a_out_data, 64'hA);
      chk("stall_hold_occ2", {62'd0, a_occ}, 64'd2);
      a_out_ready = 1;
      tick();
      chk("drain_data_B", a_out_data, 64'hB);
      chk("drain_occ1", {62'd0, a_occ}, 64'd1);
      chk("drain_in_ready1", {63'd0, a_in_ready}, 64'd1);
      tick();
      chk("drain_data_C", a_out_data, 64'hC);
      chk("drain_ctrl_C", {56'd0, a_out_ctrl}, 64'h0C);
      a_in_valid = 0;
      tick();
      chk("drain_empty", {63'd0, a_out_valid}, 64'd0);

      // Flush with occupancy 2 and an offered 0xFF control beat.
      a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h11; a_in_ctrl = 8'h11;
      tick();
      a_in_data = 64'h22; a_in_ctrl = 8'h22;
      tick();
      chk("flush_pre_occ2", {62'd0, a_occ}, 64'd2);
      a_in_data = 64'hFF; a_in_ctrl = 8'hFF; a_flush = 1;
      tick();
      chk("flush_valid0", {63'd0, a_out_valid}, 64'd0);
      chk("flush_ctrl0", {56'd0, a_out_ctrl}, 64'd0);
      chk("flush_occ0", {62'd0, a_occ}, 64'd0);
      a_flush = 0; a_in_valid = 0;
      tick();
      chk("flush_no_leak", {63'd0, a_out_valid}, 64'd0);

      // Flush while a beat is actually accepted: it must be discarded.
      a_out_ready = 1; a_in_valid = 1; a_in_data = 64'h33; a_in_ctrl = 8'h33;
      tick();
      a_in_data = 64'hFF; a_in_ctrl = 8'hFF; a_flush = 1;
      tick();
      chk("flush_acc_occ0", {62'd0, a_occ}, 64'd0);
      a_flush = 0; a_in_valid = 0;
      tick();
      chk("flush_acc_no_leak", {63'd0, a_out_valid}, 64'd0);

      // Bubble masking: ctrl zeroed at the output while storage keeps it.
      a_in_valid = 1; a_in_data = 64'h5A; a_in_ctrl = 8'hA5;
      tick();
      chk("bubble_ctrl_live", {56'd0, a_out_ctrl}, 64'hA5);
      a_in_valid = 0;
      tick();
      chk("bubble_valid0", {63'd0, a_out_valid}, 64'd0);
      chk("bubble_ctrl0", {56'd0, a_out_ctrl}, 64'd0);
      chk("bubble_mctrl_kept", {56'd0, dut1.m_ctrl_q}, 64'hA5);
      chk("bubble_data_kept", a_out_data, 64'h5A);

      // Asynchronous reset mid-cycle with two beats held.
      a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h44; a_in_ctrl = 8'h44;
      tick();
      a_in_data = 64'h55; a_in_ctrl = 8'h55;
      tick();
      chk("arst_pre_occ2", {62'd0, a_occ}, 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid0", {63'd0, a_out_valid}, 64'd0);
      chk("arst_ctrl0", {56'd0, a_out_ctrl}, 64'd0);
      chk("arst_data0", a_out_data, 64'd0);
      chk("arst_occ0", {62'd0, a_occ}, 64'd0);
      chk("arst_in_ready1", {63'd0, a_in_ready}, 64'd1);
      a_in_valid = 0;
      tick();
      rst_n = 1'b1;
      tick();

      // SKID=0: out_ready toggles under continuous in_valid; upstream advances on accept.
      or_tab  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      dat_tab = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
      exp_out = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
      b_in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         b_out_ready = or_tab[i];
         b_in_data = 64'(dat_tab[i]); b_in_ctrl = dat_tab[i];
         #1;
         chk("s0_in_ready", {63'd0, b_in_ready}, {63'd0, or_tab[i]});
         tick();
         chk("s0_out_data", b_out_data, 64'(exp_out[i]));
         chk("s0_occ", {62'd0, b_occ}, 64'd1);
      end
      b_in_valid = 0;
      tick();
      chk("s0_drained", {63'd0, b_out_valid}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a synchronous flush and an optional skid buffer. It replaces the fixed-field inter-stage latches (IF/ID … MEM/WB) of the pipelined CPU with one reusable block. It carries a data bundle and a control bundle, and forces the control bundle to zero whenever the stage holds a bubble, so write-enables such as RegWrite or MemWrite can never fire from an invalid slot. Stall and back-pressure come from `out_ready`; branch and exception squash comes from `flush_i`.

## Interface
Parameters:
- `DATA_W`, default 64: width of the data bundle (e.g. ReadData + ALUresult).
- `CTRL_W`, default 8: width of the control bundle (WriteReg, RegWrite, MemtoReg, …).
- `SKID`, default 1: 1 adds a second (skid) entry so `in_ready` is a registered signal; 0 gives a single entry with combinational `in_ready`.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_data`  in  DATA_W  upstream data bundle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  stage holds a valid beat.
- `out_ready`  in  1  downstream accepts; 0 means stall.
- `out_data`  out  DATA_W  held data bundle.
- `out_ctrl`  out  CTRL_W  held control bundle; all zeros whenever `out_valid`=0.
- `flush_i`  in  1  synchronous squash of all held beats.
- `occ_o`  out  2  entries held: 0, 1, or 2 (2 only when SKID=1).

## Operation
- Storage:
  - Main entry M: `m_valid`, `m_data`, `m_ctrl`.
  - Skid entry S (SKID=1 only): `s_valid`, `s_data`, `s_ctrl`.
- Outputs:
  - `out_valid` = `m_valid`.
  - `out_data` = `m_data`.
  - `out_ctrl` = `m_valid ? m_ctrl : 0`.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- `in_ready`:
  - SKID=1: `in_ready` = `!s_valid`, taken from a register only.
  - SKID=0: `in_ready` = `out_ready | !m_valid`.
- M update, when M is free or draining (`!m_valid | out_ready`):
  - If `s_valid`: M loads from S and S clears.
  - Else if accept: M loads from input.
  - Else: `m_valid` goes to 0 and `m_data`/`m_ctrl` keep their old values (masked at the outputs).
- M held (`m_valid & !out_ready`) with accept: beat goes to S (SKID=1). SKID=0 cannot reach this case because `in_ready`=0.
- Ordering is strict FIFO: S is always older than any newly accepted beat. Beats are never dropped or duplicated except by flush.
- `flush_i`=1 has priority over everything:
  - Next edge: `m_valid`=0 and `s_valid`=0.
  - A beat accepted in the flush cycle is discarded.
  - A drain in the flush cycle is still a legal downstream transfer.
- `occ_o` = `m_valid + s_valid`.
- Reset (`rst_i`=0, asynchronous): all valids 0, all data/ctrl registers 0.
  - Therefore `out_valid`=0, `out_data`=0, `out_ctrl`=0, `occ_o`=0.
  - `in_ready`=1 with SKID=1; with SKID=0, `in_ready`=1 as well because `m_valid`=0.
- Reset asserted mid-transfer drops all beats immediately, without waiting for a clock edge.

## Timing
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained when `out_ready`=1, for both SKID settings.
- SKID=1 under stall:
  - First stalled cycle: one further beat is absorbed into S.
  - `in_ready` falls one edge after S fills.
  - It rises one edge after the downstream drains (M reloads from S on that edge).
- SKID=1 has no combinational path from `out_ready` to `in_ready`. SKID=0 has exactly that path.
- `flush_i` takes effect at the next edge: `out_valid`=0 and `occ_o`=0 in the following cycle.
- Release from reset: first accept at the first rising edge with `rst_i`=1.

## Test plan
- **Reset:** drive `rst_i`=0 mid-cycle with `occ_o`=2 → immediately `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occ_o`=0, `in_ready`=1.
- **Streaming:** SKID=1, `out_ready`=1, 8 back-to-back beats with data 0x1…0x8 → outputs 0x1…0x8 on consecutive cycles, each one cycle after its input, `in_ready` constantly 1.
- **Stall:** SKID=1, beats A, B, C with `out_ready`=0 from the cycle A appears → A held, B stored in S, `in_ready`=0 and `occ_o`=2, C not accepted. Raise `out_ready` → A, B, C out in order with no loss.
- **Flush:** `flush_i`=1 with `occ_o`=2 and `in_valid`=1 carrying ctrl=0xFF → next cycle `out_valid`=0, `out_ctrl`=0x00, `occ_o`=0. The flushed-cycle input never appears at the output.
- **Bubble masking:** beat with ctrl=0xA5 drained, no new input → `out_ctrl`=0x00 the next cycle while `m_ctrl` still internally holds 0xA5.
- **SKID=0 mode:** `out_ready` toggles 1,0,1,0 under continuous `in_valid` → `in_ready` follows `out_ready` in the same cycle once M is full, with no beat loss or reordering.
